// File: rtl/bsg_mem_2r1w_sync_bypass_if.sv
// Signal bundle between the operand-read stage, the bypass front-end and the
// synchronous 2r1w register-file memory it drives.
interface bsg_mem_2r1w_sync_bypass_if #(
  parameter int width_p      = 32,
  parameter int addr_width_lp = 5
);
  logic                     w_v_i;
  logic [addr_width_lp-1:0] w_addr_i;
  logic [width_p-1:0]       w_data_i;

  logic                     r0_v_i;
  logic [addr_width_lp-1:0] r0_addr_i;
  logic                     r0_v_o;
  logic [width_p-1:0]       r0_data_o;

  logic                     r1_v_i;
  logic [addr_width_lp-1:0] r1_addr_i;
  logic                     r1_v_o;
  logic [width_p-1:0]       r1_data_o;

  logic                     mem_w_v_o;
  logic [addr_width_lp-1:0] mem_w_addr_o;
  logic [width_p-1:0]       mem_w_data_o;

  logic                     mem_r0_v_o;
  logic [addr_width_lp-1:0] mem_r0_addr_o;
  logic [width_p-1:0]       mem_r0_data_i;

  logic                     mem_r1_v_o;
  logic [addr_width_lp-1:0] mem_r1_addr_o;
  logic [width_p-1:0]       mem_r1_data_i;

  // The front-end's view: pipeline requests and memory read data come in.
  modport slave (
    input  w_v_i, w_addr_i, w_data_i,
    input  r0_v_i, r0_addr_i, r1_v_i, r1_addr_i,
    output r0_v_o, r0_data_o, r1_v_o, r1_data_o,
    output mem_w_v_o, mem_w_addr_o, mem_w_data_o,
    output mem_r0_v_o, mem_r0_addr_o, mem_r1_v_o, mem_r1_addr_o,
    input  mem_r0_data_i, mem_r1_data_i
  );

  // The surrounding environment's view (pipeline plus memory).
  modport master (
    output w_v_i, w_addr_i, w_data_i,
    output r0_v_i, r0_addr_i, r1_v_i, r1_addr_i,
    input  r0_v_o, r0_data_o, r1_v_o, r1_data_o,
    input  mem_w_v_o, mem_w_addr_o, mem_w_data_o,
    input  mem_r0_v_o, mem_r0_addr_o, mem_r1_v_o, mem_r1_addr_o,
    output mem_r0_data_i, mem_r1_data_i
  );
endinterface

// File: rtl/bsg_mem_2r1w_sync_bypass.sv
// Bypassing front-end for a 2r1w synchronous register file: forwards same-cycle
// write data, optionally hardwires address 0, and holds read data when idle.
module bsg_mem_2r1w_sync_bypass #(
  parameter int width_p    = -1,
  parameter int els_p      = -1,
  parameter int zero_reg_p = 0,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input logic clk_i,
  input logic reset_i,
  bsg_mem_2r1w_sync_bypass_if.slave bus
);

  typedef enum logic [1:0] {SRC_ZERO, SRC_BYPASS, SRC_MEM} src_e;

  logic w_zero;
  logic mem_w_v;

  assign w_zero  = (zero_reg_p != 0) && (bus.w_addr_i == '0);
  assign mem_w_v = bus.w_v_i & ~reset_i & ~w_zero;

  assign bus.mem_w_v_o    = mem_w_v;
  assign bus.mem_w_addr_o = bus.w_addr_i;
  assign bus.mem_w_data_o = bus.w_data_i;

  logic [1:0]               r_v;
  logic [1:0]               mem_r_v;
  logic [1:0]               r_v_out;
  logic [addr_width_lp-1:0] r_addr   [2];
  logic [width_p-1:0]       mem_data [2];
  logic [width_p-1:0]       r_data   [2];

  assign r_v         = {bus.r1_v_i, bus.r0_v_i};
  assign r_addr[0]   = bus.r0_addr_i;
  assign r_addr[1]   = bus.r1_addr_i;
  assign mem_data[0] = bus.mem_r0_data_i;
  assign mem_data[1] = bus.mem_r1_data_i;

  assign bus.mem_r0_v_o    = mem_r_v[0];
  assign bus.mem_r1_v_o    = mem_r_v[1];
  assign bus.mem_r0_addr_o = r_addr[0];
  assign bus.mem_r1_addr_o = r_addr[1];
  assign bus.r0_v_o        = r_v_out[0];
  assign bus.r1_v_o        = r_v_out[1];
  assign bus.r0_data_o     = r_data[0];
  assign bus.r1_data_o     = r_data[1];

  for (genvar k = 0; k < 2; k++) begin : g_port
    src_e               src;
    src_e               src_r;
    logic               v_r;
    logic [width_p-1:0] byp_r;
    logic [width_p-1:0] hold_r;
    logic [width_p-1:0] data;

    always_comb begin
      if ((zero_reg_p != 0) && (r_addr[k] == '0))
        src = SRC_ZERO;
      else if (mem_w_v && (bus.w_addr_i == r_addr[k]))
        src = SRC_BYPASS;
      else
        src = SRC_MEM;
    end

    // Bypassed and zero reads never reach the memory, so it never sees a
    // same-address read/write pair.
    assign mem_r_v[k] = r_v[k] & ~reset_i & (src == SRC_MEM);

    always_comb begin
      // NOTE: default assignment first so every path drives data -- no latch.
      data = hold_r;
      if (v_r) begin
        unique case (src_r)
          SRC_ZERO:   data = '0;
          SRC_BYPASS: data = byp_r;
          SRC_MEM:    data = mem_data[k];
          default:    data = hold_r;
        endcase
      end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        v_r    <= 1'b0;
        src_r  <= SRC_ZERO;
        byp_r  <= '0;
        hold_r <= '0;
      end else begin
        v_r    <= r_v[k];
        hold_r <= data;
        if (r_v[k]) begin
          src_r <= src;
          if (src == SRC_BYPASS)
            byp_r <= bus.w_data_i;
        end
      end
    end

    assign r_v_out[k] = v_r;
    assign r_data[k]  = data;

    a_r_addr_range: assert property (@(posedge clk_i) disable iff (reset_i)
      r_v[k] |-> (32'(r_addr[k]) < els_p))
      else $error("read port %0d address %0d out of range", k, r_addr[k]);

    a_no_rw_conflict: assert property (@(posedge clk_i) disable iff (reset_i)
      !(mem_w_v && mem_r_v[k] && (bus.w_addr_i == r_addr[k])))
      else $error("memory port %0d read collides with write to %0d", k, r_addr[k]);
  end

  a_w_addr_range: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.w_v_i |-> (32'(bus.w_addr_i) < els_p))
    else $error("write address %0d out of range", bus.w_addr_i);

endmodule

// File: tb/tb_bsg_mem_2r1w_sync_bypass.sv
// Self-checking bench: directed scenarios then random traffic, compared against
// an architectural register-file model; the bench also plays the memory.
module tb_bsg_mem_2r1w_sync_bypass;
  localparam int WIDTH    = 32;
  localparam int ELS      = 12;
  localparam int AW       = 4;
  localparam bit ZERO_REG = 1'b1;

  logic clk = 1'b0;
  logic reset;

  bsg_mem_2r1w_sync_bypass_if #(.width_p(WIDTH), .addr_width_lp(AW)) bus ();

  bsg_mem_2r1w_sync_bypass #(
    .width_p(WIDTH), .els_p(ELS), .zero_reg_p(1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory stand-in: returns garbage when not read and X on a
  // same-address read/write, so any misuse of its output shows up.
  logic [WIDTH-1:0] tb_mem [ELS];
  always @(posedge clk) begin
    if (bus.mem_r0_v_o)
      bus.mem_r0_data_i <= (bus.mem_w_v_o && bus.mem_w_addr_o == bus.mem_r0_addr_o)
                           ? 'x : tb_mem[bus.mem_r0_addr_o];
    else
      bus.mem_r0_data_i <= $urandom;
    if (bus.mem_r1_v_o)
      bus.mem_r1_data_i <= (bus.mem_w_v_o && bus.mem_w_addr_o == bus.mem_r1_addr_o)
                           ? 'x : tb_mem[bus.mem_r1_addr_o];
    else
      bus.mem_r1_data_i <= $urandom;
    if (bus.mem_w_v_o)
      tb_mem[bus.mem_w_addr_o] <= bus.mem_w_data_o;
  end

  // Architectural model: register contents plus what each port last returned.
  logic [WIDTH-1:0] ref_mem [ELS];
  logic             exp_v    [2];
  logic [WIDTH-1:0] exp_data [2];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check the combinational memory-side
  // outputs, then check the registered read returns just after the posedge.
  task automatic step(input bit rst, input bit wv, input int wa,
                      input logic [WIDTH-1:0] wd,
                      input bit v0, input int a0, input bit v1, input int a1);
    bit               rv [2];
    int               ra [2];
    bit               ew;
    bit               byp;
    logic [WIDTH-1:0] val [2];
    bit               exp_mrv [2];

    @(negedge clk);
    reset         = rst;
    bus.w_v_i     = wv;
    bus.w_addr_i  = AW'(wa);
    bus.w_data_i  = wd;
    bus.r0_v_i    = v0;
    bus.r0_addr_i = AW'(a0);
    bus.r1_v_i    = v1;
    bus.r1_addr_i = AW'(a1);
    #1;

    rv[0] = v0; rv[1] = v1;
    ra[0] = a0; ra[1] = a1;
    ew = wv && !rst && !(ZERO_REG && wa == 0);
    check("mem_w_v", 32'(bus.mem_w_v_o), 32'(ew));
    check("mem_w_addr", 32'(bus.mem_w_addr_o), 32'(wa));
    check("mem_w_data", bus.mem_w_data_o, wd);

    for (int k = 0; k < 2; k++) begin
      byp = ew && (wa == ra[k]);
      if (ZERO_REG && ra[k] == 0) val[k] = '0;
      else if (byp)               val[k] = wd;
      else                        val[k] = ref_mem[ra[k]];
      exp_mrv[k] = rv[k] && !rst && !(ZERO_REG && ra[k] == 0) && !byp;
    end
    check("mem_r0_v", 32'(bus.mem_r0_v_o), 32'(exp_mrv[0]));
    check("mem_r1_v", 32'(bus.mem_r1_v_o), 32'(exp_mrv[1]));
    check("mem_r0_addr", 32'(bus.mem_r0_addr_o), 32'(a0));
    check("mem_r1_addr", 32'(bus.mem_r1_addr_o), 32'(a1));

    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        exp_v[k] = 1'b0;  exp_data[k] = '0;
      end else if (rv[k]) begin
        exp_v[k] = 1'b1;  exp_data[k] = val[k];
      end else begin
        exp_v[k] = 1'b0;
      end
    end
    if (ew) ref_mem[wa] = wd;

    check("r0_v", 32'(bus.r0_v_o), 32'(exp_v[0]));
    check("r0_data", bus.r0_data_o, exp_data[0]);
    check("r1_v", 32'(bus.r1_v_o), 32'(exp_v[1]));
    check("r1_data", bus.r1_data_o, exp_data[1]);
  endtask

  initial begin
    for (int i = 0; i < ELS; i++) begin
      ref_mem[i] = '0;
      tb_mem[i]  = '0;
    end
    reset = 1'b1;
    bus.w_v_i = 1'b0; bus.w_addr_i = '0; bus.w_data_i = '0;
    bus.r0_v_i = 1'b0; bus.r0_addr_i = '0;
    bus.r1_v_i = 1'b0; bus.r1_addr_i = '0;
    bus.mem_r0_data_i = '0; bus.mem_r1_data_i = '0;

    // Reset, including reads and a write issued while reset is high.
    step(1, 1, 2, 32'h1234, 1, 2, 1, 4);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Write then read through the memory.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0, 0);

    // Same-cycle bypass on both ports, then a memory read of the new value.
    step(0, 1, 3, 32'h11, 0, 0, 0, 0);
    step(0, 1, 3, 32'h22, 1, 3, 1, 3);
    step(0, 0, 0, 0, 1, 3, 1, 3);

    // Read-before-write ordering.
    step(0, 1, 7, 32'hA, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 1, 7, 32'hB, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7);

    // Zero register: writes dropped, reads return 0 without a memory access.
    step(0, 1, 0, 32'hFFFF, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);

    // Hold across idle cycles while memory output churns, then mid-stream reset.
    step(0, 1, 9, 32'h55, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 1, 9);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 9, 1, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional resets; small address space for collisions.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, ELS - 1), $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, ELS - 1),
           1'($urandom_range(0, 1)), $urandom_range(0, ELS - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_mem_2r1w_sync_bypass.md
Name: bsg_mem_2r1w_sync_bypass

Overview:
- Read/write front-end for a 2-read/1-write synchronous register file.
- Sits directly between the pipeline's operand-read stage and the synchronous 2r1w memory. It drives the memory's ports and consumes its read data.
- Removes the memory's same-address read/write restriction by forwarding write data.
- Optionally hardwires address 0 to zero.
- Holds read data stable across idle cycles, so downstream logic never samples undefined memory output.

Parameters:
- width_p, -1 (required): data width in bits.
- els_p, -1 (required): number of entries.
- zero_reg_p, 0: when 1, address 0 always reads as 0 and writes to address 0 are dropped.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p): address width (derived).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- w_v_i  in  1  write request
- w_addr_i  in  addr_width_lp  write address
- w_data_i  in  width_p  write data
- r0_v_i  in  1  port-0 read request
- r0_addr_i  in  addr_width_lp  port-0 read address
- r0_v_o  out  1  port-0 read data valid (one cycle after the request)
- r0_data_o  out  width_p  port-0 read data
- r1_v_i, r1_addr_i, r1_v_o, r1_data_o: same as port 0, for port 1
- mem_w_v_o  out  1  memory write enable
- mem_w_addr_o  out  addr_width_lp  memory write address
- mem_w_data_o  out  width_p  memory write data
- mem_r0_v_o  out  1  memory port-0 read enable
- mem_r0_addr_o  out  addr_width_lp  memory port-0 read address
- mem_r0_data_i  in  width_p  memory port-0 read data (valid the cycle after mem_r0_v_o)
- mem_r1_v_o, mem_r1_addr_o, mem_r1_data_i: same as memory port 0, for port 1

Behaviour:
- One clock (clk_i). Reset is synchronous, active-high. All state updates on posedge clk_i.
- Write path (combinational passthrough):
  - mem_w_v_o = w_v_i & ~reset_i & ~(zero_reg_p & w_addr_i==0).
  - mem_w_addr_o = w_addr_i; mem_w_data_o = w_data_i.
- Read issue, cycle t, each port k independently. Source is chosen in priority order:
  - ZERO if zero_reg_p and rk_addr_i==0;
  - else BYPASS if mem_w_v_o and w_addr_i==rk_addr_i;
  - else MEM.
- mem_rk_v_o = rk_v_i & ~reset_i & (source==MEM). The memory therefore never sees a same-address read/write.
- mem_rk_addr_o = rk_addr_i (passthrough).
- Registered at t (only when rk_v_i & ~reset_i): v_r<=1, src_r<=source. If source==BYPASS, byp_r<=w_data_i. Otherwise v_r<=0.
- Read return, cycle t+1:
  - rk_v_o = v_r.
  - rk_data_o = 0 if src_r==ZERO; byp_r if BYPASS; mem_rk_data_i if MEM.
  - If v_r==0, rk_data_o = hold_r.
  - hold_r <= rk_data_o every cycle.
- Latency is exactly 1 cycle. Throughput is one read per port per cycle, back-to-back, with no stalls.
- Ordering:
  - Read and write to the same address in the same cycle returns the new (write) data.
  - A write in cycle t+1 to an address read at t does not affect the data returned at t+1 (old value).
  - The two ports may read the same address in the same cycle; both return identical data.
- Idle: rk_data_o holds its last returned value indefinitely, irrespective of mem_rk_data_i activity.
- Reset:
  - While reset_i is high: all mem_*_v_o=0; v_r, src_r, byp_r and hold_r are cleared.
  - First cycle after reset deassertion: rk_v_o=0, rk_data_o=0.
  - A read issued in the same cycle reset_i is high is discarded (no rk_v_o the next cycle).
- Simulation-only checks, enabled when not in reset:
  - $error if a valid write or read address is >= els_p.
  - $error if mem_w_v_o and mem_rk_v_o target the same address.

Test Plan:
1. Reset, then idle: reset_i=1 for 2 cycles, then 0 -> r0_v_o=r1_v_o=0, r0_data_o=r1_data_o=0, all mem_*_v_o=0 during reset.
2. Write then read: write addr 5 = 0xDEADBEEF at t; r0 read addr 5 at t+1 -> mem_r0_v_o=1 at t+1; r0_v_o=1 with r0_data_o=0xDEADBEEF at t+2.
3. Same-cycle bypass: addr 3 holds 0x11; write addr 3 = 0x22 while r0 and r1 both read addr 3 -> mem_r0_v_o=mem_r1_v_o=0 that cycle; next cycle both ports return 0x22; a later read of addr 3 via memory returns 0x22.
4. Read-before-write ordering: addr 7 = 0xA; read addr 7 at t, write addr 7 = 0xB at t+1 -> data at t+1 is 0xA; a read at t+1 returns 0xB at t+2.
5. Zero register (zero_reg_p=1): write addr 0 = 0xFFFF -> mem_w_v_o=0; read addr 0 concurrently and afterwards -> returns 0, mem_r0_v_o=0.
6. Hold and mid-stream reset: read returns 0x55, then 4 idle cycles while mem_r0_data_i toggles -> r0_data_o stays 0x55; assert reset_i with a read issued -> next cycle r0_v_o=0, r0_data_o=0.
